// File: rtl/rom2ram_pkg.sv
// rtl/rom2ram_pkg.sv - shared types and constants for the ROM-to-RAM copy sequencer
package rom2ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Power-on value of the latched length; never used to drive a transfer.
  localparam int unsigned DEFAULT_LEN = 1;

endpackage

// File: rtl/rom2ram_addr_cnt.sv
// rtl/rom2ram_addr_cnt.sv - loadable base plus offset counter, address output wraps to AW bits
module rom2ram_addr_cnt
  import rom2ram_pkg::*;
#(
  parameter int AW = 3,
  parameter int OW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [AW-1:0] base_i,
  input  logic          inc_i,
  output logic [AW-1:0] addr_o,
  output logic [OW-1:0] off_o
);

  localparam int SW = (AW > OW) ? AW : OW;

  logic [AW-1:0] base_q, base_d;
  logic [OW-1:0] off_q, off_d;
  logic [SW-1:0] sum;

  always_comb begin
    base_d = base_q;
    off_d  = off_q;
    if (load_i) begin
      base_d = base_i;
      off_d  = '0;
    end else if (inc_i) begin
      off_d = off_q + OW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= '0;
      off_q  <= '0;
    end else begin
      base_q <= base_d;
      off_q  <= off_d;
    end
  end

  // Sum at the wider width, then keep only the low AW bits for the modulo wrap.
  assign sum    = SW'(base_q) + SW'(off_q);
  assign addr_o = sum[AW-1:0];
  assign off_o  = off_q;

endmodule

// File: rtl/rom2ram_xfer_ctrl.sv
// rtl/rom2ram_xfer_ctrl.sv - copies a block of words from a registered-read ROM into RAM port A
module rom2ram_xfer_ctrl
  import rom2ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROM_DEPTH  = 8,
  parameter int RAM_AW     = 4,
  parameter int LEN_W      = 4,
  localparam int ROM_AW    = $clog2(ROM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ROM_AW-1:0]     src_base_i,
  input  logic [RAM_AW-1:0]     dst_base_i,
  input  logic [LEN_W-1:0]      length_i,
  output logic [ROM_AW-1:0]     rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [RAM_AW-1:0]     ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_din_o,
  output logic                  ram_we_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_W-1:0]      count_o
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             wr_valid_q, wr_valid_d;
  logic             load;
  logic             rd_inc;
  logic [LEN_W-1:0] rd_idx;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_valid_d = 1'b0;
    load       = 1'b0;
    rd_inc     = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          len_d   = length_i;
          state_d = (length_i == '0) ? DONE : XFER;
        end
      end
      XFER: begin
        busy_o = 1'b1;
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          // The ROM read issued this cycle lands next cycle, so flag it for the write stage.
          wr_valid_d = 1'b1;
          if (rd_idx == len_q - LEN_W'(1)) begin
            state_d = DRAIN;
          end else begin
            rd_inc = 1'b1;
          end
        end
      end
      DRAIN: begin
        busy_o  = 1'b1;
        state_d = abort_i ? IDLE : DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      len_q      <= LEN_W'(DEFAULT_LEN);
      wr_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_valid_q <= wr_valid_d;
    end
  end

  rom2ram_addr_cnt #(
    .AW (ROM_AW),
    .OW (LEN_W)
  ) u_rd_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .base_i (src_base_i),
    .inc_i  (rd_inc),
    .addr_o (rom_addr_o),
    .off_o  (rd_idx)
  );

  // The write offset doubles as the words-written count.
  rom2ram_addr_cnt #(
    .AW (RAM_AW),
    .OW (LEN_W)
  ) u_wr_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .base_i (dst_base_i),
    .inc_i  (wr_valid_q),
    .addr_o (ram_addr_o),
    .off_o  (count_o)
  );

  assign ram_we_o  = wr_valid_q;
  assign ram_din_o = rom_data_i;

endmodule

// File: tb/tb_rom2ram_xfer_ctrl.sv
// tb/tb_rom2ram_xfer_ctrl.sv - directed and randomized checks of rom2ram_xfer_ctrl against a reference model
module tb_rom2ram_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] src_base = '0;
  logic [3:0] dst_base = '0;
  logic [3:0] length = '0;
  logic [2:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic       busy;
  logic       done;
  logic [3:0] count;

  logic [7:0] rom[8];
  logic [7:0] ram[16];
  logic [7:0] exp_ram[16];
  logic       ram_init = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rom2ram_xfer_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .abort_i    (abort),
    .src_base_i (src_base),
    .dst_base_i (dst_base),
    .length_i   (length),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .ram_we_o   (ram_we),
    .busy_o     (busy),
    .done_o     (done),
    .count_o    (count)
  );

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_writes(input int src, input int dst, input int n);
    for (int i = 0; i < n; i++) exp_ram[(dst + i) % 16] = rom[(src + i) % 8];
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s ram[%0d]", tag, i), ram[i], exp_ram[i]);
  endtask

  // One transfer; abort_at = cycle in which abort is held (0 = none).
  task automatic run(input int src, input int dst, input int len, input int abort_at,
                     input bit restart, input int tail, input string tag);
    int  wr_total, done_cyc, last;
    bit  aborted, live;
    aborted  = (abort_at > 0);
    wr_total = aborted ? clamp(abort_at - 1, 0, len) : len;
    done_cyc = aborted ? 0 : ((len == 0) ? 1 : len + 2);
    last     = (aborted ? abort_at + 1 : done_cyc) + tail;
    @(negedge clk);
    src_base = 3'(src);
    dst_base = 4'(dst);
    length   = 4'(len);
    start    = 1'b1;
    abort    = 1'($urandom % 2);
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      live = !aborted || (c <= abort_at);
      chk($sformatf("%s c%0d busy", tag, c), busy, live && len > 0 && c <= len + 1);
      chk($sformatf("%s c%0d done", tag, c), done, !aborted && c == done_cyc);
      chk($sformatf("%s c%0d we", tag, c), ram_we, live && len > 0 && c >= 2 && c <= len + 1);
      chk($sformatf("%s c%0d count", tag, c), count, clamp(c - 2, 0, wr_total));
      if (live && len > 0 && c <= len)
        chk($sformatf("%s c%0d rom_addr", tag, c), rom_addr, (src + c - 1) % 8);
      if (live && len > 0 && c >= 2 && c <= len + 1) begin
        chk($sformatf("%s c%0d ram_addr", tag, c), ram_addr, (dst + c - 2) % 16);
        chk($sformatf("%s c%0d ram_din", tag, c), ram_din, rom[(src + c - 2) % 8]);
      end
      start = restart && (c <= done_cyc);
      abort = (c == abort_at);
      if (restart) begin
        src_base = 3'($urandom);
        dst_base = 4'($urandom);
        length   = 4'($urandom);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    model_writes(src, dst, wr_total);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 8'(8'h10 + i);
    for (int i = 0; i < 16; i++) exp_ram[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset we", ram_we, 0);
    chk("reset count", count, 0);
    chk("reset rom_addr", rom_addr, 0);
    chk("reset ram_addr", ram_addr, 0);
    rst = 1'b0;
    ram_init = 1'b0;

    run(2, 5, 4, 0, 1'b0, 1, "basic");
    check_ram("basic");
    chk("basic ram5", ram[5], 8'h12);
    chk("basic ram8", ram[8], 8'h15);

    run(0, 3, 0, 0, 1'b0, 1, "len0");
    check_ram("len0");

    run(6, 14, 4, 0, 1'b0, 1, "wrap");
    chk("wrap ram14", ram[14], 8'h16);
    chk("wrap ram15", ram[15], 8'h17);
    chk("wrap ram0", ram[0], 8'h10);
    chk("wrap ram1", ram[1], 8'h11);
    check_ram("wrap");

    run(1, 8, 6, 4, 1'b0, 1, "abort");
    chk("abort count", count, 3);
    check_ram("abort");

    run(3, 2, 3, 0, 1'b1, 1, "restart");
    check_ram("restart");

    // Reset in the third cycle of a six-word copy: two writes land, then everything clears.
    @(negedge clk);
    src_base = 3'd0;
    dst_base = 4'd10;
    length   = 4'd6;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst we", ram_we, 0);
    chk("midrst count", count, 0);
    chk("midrst rom_addr", rom_addr, 0);
    chk("midrst ram_addr", ram_addr, 0);
    rst = 1'b0;
    model_writes(0, 10, 2);
    @(negedge clk);
    chk("midrst we after", ram_we, 0);
    check_ram("midrst");

    run(0, 9, 5, 0, 1'b0, 0, "b2b_a");
    run(4, 1, 3, 0, 1'b0, 2, "b2b_b");
    check_ram("b2b");

    for (int i = 0; i < 8; i++) rom[i] = 8'($urandom);
    for (int r = 0; r < 10; r++) begin
      int len, ab;
      len = int'($urandom_range(0, 15));
      ab  = (len > 0 && ($urandom % 3 == 0)) ? int'($urandom_range(1, len + 1)) : 0;
      run(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), len, ab,
          1'($urandom % 2), 1, $sformatf("rnd%0d", r));
      check_ram($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
